uart_rx_param: RTL

//  Parametrised, oversampled UART receiver; successor to the fixed 8N1 receiver.

---
 rtl/uart_rx_param.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver: configurable width/parity/stop, 1-entry output register.
// Optional 2-of-3 majority sampling: define UART_RX_MAJORITY_EN.
module uart_rx_param #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16,
  parameter int PARITY     = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun_err,
  output logic            busy
);

  localparam int SMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(DBIT);

  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          ODD    = (PARITY == 1);

`ifdef UART_RX_MAJORITY_EN
  // Start decision waits one extra tick so the window is centred on mid-bit.
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
`else
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t          state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic            perr, perr_n;
  logic            ferr, ferr_n;
  logic            done;
  logic            rx_q, rx_s, rx_prev;
  logic            sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_q    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_q    <= rx;
      rx_s    <= rx_q;
      rx_prev <= rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Window = {ticks point-1, point} from history plus the current tick.
  logic [1:0] hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= 2'b11;
    end else if (s_tick) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign sample = (hist[1] & hist[0]) |
                  (hist[1] & rx_s) |
                  (hist[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_n;
      s     <= s_n;
      n     <= n_n;
      b     <= b_n;
      perr  <= perr_n;
      ferr  <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    perr_n  = perr;
    ferr_n  = ferr;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_MID) begin
            if (sample) begin
              state_n = IDLE;
              s_n     = '0;
            end else begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
              perr_n  = 1'b0;
              ferr_n  = 1'b0;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_LAST) begin
            s_n = '0;
            b_n = {sample, b[DBIT-1:1]};
            if (n == N_LAST) begin
              state_n = (PARITY != 0) ? PAR : STOP;
            end else begin
              n_n = n + 1'b1;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      PAR: begin
        if (s_tick) begin
          if (s == S_LAST) begin
            perr_n  = sample ^ (^b) ^ ODD;
            s_n     = '0;
            state_n = STOP;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_LAST) begin
            ferr_n = ~sample;
          end
          if (s == S_STOP) begin
            done    = 1'b1;
            state_n = IDLE;
            s_n     = '0;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        s_n     = '0;
      end
    endcase
  end

  // Output register: a completed frame is dropped if the held word is not taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_dout     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else if (done) begin
      if (!rx_valid || rx_ready) begin
        rx_dout     <= b;
        rx_valid    <= 1'b1;
        frame_err   <= ferr_n;
        parity_err  <= perr;
        overrun_err <= 1'b0;
      end else begin
        overrun_err <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule
